// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the PC, issues word requests to instruction
// memory under a credit limit, queues returned words in a small FIFO and
// presents the head with opcode/funct split out. A redirect (taken branch)
// flushes the queue and discards every response still in flight.
//
// Handshakes (all sampled on the rising clock edge):
//   imem_req/imem_gnt     : a request transfers when imem_req & imem_gnt.
//                           imem_addr is held stable while imem_req is high
//                           and not yet granted.
//   imem_rvalid           : one response per transferred request, in order.
//                           It carries no back-pressure because the credit
//                           scheme always reserves a queue slot.
//   inst_valid/inst_ready : the head entry transfers when inst_valid &
//                           inst_ready. The head is held until it is taken.
`timescale 1ns/1ps

module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [31:0] pc4,
  output logic [5:0]  opcode,
  output logic [5:0]  funct
);

  // Pointer width indexes the storage; count width must also hold DEPTH.
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_C = DEPTH[CW:0];
  localparam logic [CW-1:0] ONE_C = {{(CW-1){1'b0}}, 1'b1};

  // Architectural state
  logic [31:0]   pc_q;           // next address to request
  logic [31:0]   resp_pc_q;      // address of the next response to be kept
  logic [CW-1:0] outstanding_q;  // accepted requests not yet answered
  logic [CW-1:0] drop_q;         // of those, how many are stale
  logic [CW-1:0] count_q;        // occupied queue entries
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [31:0]   word_mem [DEPTH];
  logic [31:0]   pc_mem   [DEPTH];

  // Per-cycle events
  logic          accept;         // request transferred to memory
  logic          resp_seen;      // response that matches an outstanding request
  logic          resp_keep;      // response that is pushed into the queue
  logic          pop;            // head consumed by the decoder
  logic [CW:0]   credit_used;
  logic [CW-1:0] outstanding_nxt;
  logic [31:0]   redirect_target;

  // Every entry already queued or still in flight owns a slot, so a new
  // request is only allowed while a slot remains free.
  assign credit_used     = {1'b0, count_q} + {1'b0, outstanding_q};
  assign imem_req        = reset & ~redirect & (credit_used < DEPTH_C);
  assign imem_addr       = pc_q;
  assign redirect_target = {redirect_pc[31:2], 2'b00};

  assign accept    = imem_req & imem_gnt;
  // A response with nothing outstanding cannot belong to this block.
  assign resp_seen = imem_rvalid & (outstanding_q != '0);
  // Stale responses are burned first; a response arriving alongside a
  // redirect is already on the wrong path.
  assign resp_keep = resp_seen & (drop_q == '0) & ~redirect;
  assign pop       = inst_valid & inst_ready & ~redirect;

  // Outstanding count after this cycle's grant and response; on a redirect
  // this is exactly the number of responses that must be thrown away.
  always_comb begin
    outstanding_nxt = outstanding_q;
    if (accept)    outstanding_nxt = outstanding_nxt + ONE_C;
    if (resp_seen) outstanding_nxt = outstanding_nxt - ONE_C;
  end

  // Request PC and the PC paired with each kept response.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_q      <= RESET_PC;
      resp_pc_q <= RESET_PC;
    end else if (redirect) begin
      pc_q      <= redirect_target;
      resp_pc_q <= redirect_target;
    end else begin
      if (accept)    pc_q      <= pc_q + 32'd4;
      if (resp_keep) resp_pc_q <= resp_pc_q + 32'd4;
    end
  end

  // In-flight bookkeeping: outstanding requests and stale responses to skip.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      outstanding_q <= '0;
      drop_q        <= '0;
    end else begin
      outstanding_q <= outstanding_nxt;
      if (redirect) begin
        drop_q <= outstanding_nxt;
      end else if (resp_seen && (drop_q != '0)) begin
        drop_q <= drop_q - ONE_C;
      end
    end
  end

  // Queue storage; cleared on reset so the head outputs read zero.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        word_mem[i] <= '0;
        pc_mem[i]   <= '0;
      end
    end else if (resp_keep) begin
      word_mem[wr_ptr_q] <= imem_rdata;
      pc_mem[wr_ptr_q]   <= resp_pc_q;
    end
  end

  // Queue pointers and occupancy; a redirect empties the queue outright.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (redirect) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (resp_keep) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)       rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({resp_keep, pop})
        2'b10:   count_q <= count_q + ONE_C;
        2'b01:   count_q <= count_q - ONE_C;
        default: count_q <= count_q;
      endcase
    end
  end

  // Head presentation; values are meaningful only while inst_valid is high.
  assign inst_valid = (count_q != '0);
  assign inst       = word_mem[rd_ptr_q];
  assign inst_pc    = pc_mem[rd_ptr_q];
  assign pc4        = inst_pc + 32'd4;
  assign opcode     = inst[31:26];
  assign funct      = inst[5:0];

endmodule
